// File: rtl/spi_controller.sv
// SPI mode-0 (CPOL=0, CPHA=0) controller: drives cs_n/sclk/mosi from clk through an
// integer divider, shifts WIDTH bits MSB-first and returns the captured miso word.
module spi_controller #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             div_last;

  assign div_last = (div_q == DIV_LAST);

  // Reset wins over ena; with ena low every register, done included, holds.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rstb) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sr_d   = tx_data;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          div_d     = '0;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end

      // cs_n setup time; the first sclk rise doubles as the exit edge.
      SETUP: begin
        if (div_last) begin
          div_d     = '0;
          sclk_d    = 1'b1;
          rx_sr_d   = {rx_sr_q[WIDTH-2:0], miso};
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      SHIFT: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_sr_d   = {rx_sr_q[WIDTH-2:0], miso};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
              state_d = HOLD;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_last) begin
          div_d     = '0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          state_d   = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = tx_sr_q[WIDTH-1];
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: directed vector table, hand-written corner
// sequences and randomized transfers compared cycle by cycle against a timing formula model.
module tb_spi_controller;

  localparam int W      = 8;
  localparam int C      = 2;
  localparam int DONE_N = (2 * W + 1) * C;

  logic         clk = 1'b0;
  logic         rstb, ena, start;
  logic [W-1:0] tx_data, rx_data;
  logic         miso, sclk, cs_n, mosi, busy, done;
  logic         loopback, miso_drv;

  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           done_pulses = 0;
  logic [W-1:0] prev_rx;

  assign miso = loopback ? mosi : miso_drv;

  spi_controller #(.WIDTH(W), .CLK_DIV(C)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .start   (start),
    .tx_data (tx_data),
    .miso    (miso),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: n counts enabled clk edges since the accepting edge.
  function automatic int falls(input int n);
    int f;
    f = n / (2 * C);
    return (f > W) ? W : f;
  endfunction

  function automatic logic m_sclk(input int n);
    return (n >= C) && (n < DONE_N) && ((n / C) % 2 == 1);
  endfunction

  function automatic logic m_mosi(input int n, input logic [W-1:0] tx);
    int f;
    f = falls(n);
    if (f >= W) return 1'b0;
    return tx[W-1-f];
  endfunction

  function automatic bit is_rise(input int m);
    return (m >= C) && (m < 2 * W * C) && (m % (2 * C) == C);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: miso looped to mosi; 1: peripheral shifts pword on sclk falls; 2: random miso.
  task automatic do_transfer(input string tag, input logic [W-1:0] tx, input int mode,
                             input logic [W-1:0] pword, input int off_at, input int off_len,
                             input bit rand_ena, input bit hold_start,
                             output int done_wall);
    logic [W-1:0] rec;
    logic [W+4:0] expv, actv;
    logic         mv;
    int           n, wall, off_left;
    bit           off_used, ena_nxt;
    rec      = '0;
    loopback = (mode == 0);
    miso_drv = pword[W-1];
    tx_data  = tx;
    start    = 1'b1;
    ena      = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    tx_data  = W'($urandom);
    n        = 0;
    wall     = 0;
    off_left = 0;
    off_used = 1'b0;
    forever begin
      expv = {m_sclk(n), (n >= DONE_N), m_mosi(n, tx), (n < DONE_N), (n == DONE_N),
              (n == DONE_N) ? rec : prev_rx};
      actv = {sclk, cs_n, mosi, busy, done, rx_data};
      check($sformatf("%s n=%0d {sclk,cs_n,mosi,busy,done,rx}", tag, n), 32'(actv), 32'(expv));
      if (n == DONE_N) break;
      if (!rand_ena && !off_used && n == off_at) begin
        off_left = off_len;
        off_used = 1'b1;
      end
      if (off_left > 0) begin
        ena_nxt = 1'b0;
        off_left--;
      end else begin
        ena_nxt = rand_ena ? ($urandom_range(3) != 0) : 1'b1;
      end
      case (mode)
        0:       mv = m_mosi(n, tx);
        1:       mv = (falls(n) < W) ? pword[W-1-falls(n)] : 1'b0;
        default: mv = 1'($urandom);
      endcase
      miso_drv = mv;
      if (ena_nxt && is_rise(n + 1)) rec[W-1-((n+1-C)/(2*C))] = mv;
      if (!hold_start && rand_ena) start = 1'($urandom);
      ena = ena_nxt;
      tick();
      wall++;
      if (ena_nxt) n++;
      if (wall > 1000) begin
        check($sformatf("%s timeout", tag), 32'(wall), 32'(0));
        break;
      end
    end
    done_wall = wall;
    prev_rx   = rec;
    ena       = 1'b1;
    if (!hold_start) begin
      start = 1'b0;
      tick();
      check($sformatf("%s post {cs_n,busy,done,sclk,mosi}", tag),
            32'({cs_n, busy, done, sclk, mosi}), 32'(5'b10000));
    end
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] tx;
    int           mode;
    logic [W-1:0] pword;
    int           off_at;
    int           off_len;
    bit           hold;
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dw, base, mode;
    logic [W-1:0] tx, pw;

    vecs[0] = '{"loop_a5",   8'hA5, 0, 8'h00, -1, 0, 1'b0, 8'hA5};
    vecs[1] = '{"periph_3c", 8'h00, 1, 8'h3C, -1, 0, 1'b0, 8'h3C};
    vecs[2] = '{"periph_ff", 8'hFF, 1, 8'hFF, -1, 0, 1'b0, 8'hFF};
    vecs[3] = '{"hold_12",   8'h12, 0, 8'h00, -1, 0, 1'b1, 8'h12};
    vecs[4] = '{"hold_34",   8'h34, 0, 8'h00, -1, 0, 1'b0, 8'h34};
    vecs[5] = '{"ena_gap",   8'hC3, 0, 8'h00, 10, 5, 1'b0, 8'hC3};

    // Reset held with start high; first reset edge also has ena low.
    rstb     = 1'b0;
    ena      = 1'b0;
    start    = 1'b1;
    tx_data  = 8'hFF;
    loopback = 1'b0;
    miso_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset cyc%0d {sclk,cs_n,mosi,busy,done,rx}", i),
            32'({sclk, cs_n, mosi, busy, done, rx_data}), 32'({5'b01000, 8'h00}));
      ena = 1'b1;
    end
    start = 1'b0;
    rstb  = 1'b1;
    tick();
    check("after reset idle {cs_n,busy,done}", 32'({cs_n, busy, done}), 32'(3'b100));
    prev_rx = '0;

    for (int i = 0; i < 6; i++) begin
      if (i == 3) base = done_pulses;
      do_transfer(vecs[i].name, vecs[i].tx, vecs[i].mode, vecs[i].pword,
                  vecs[i].off_at, vecs[i].off_len, 1'b0, vecs[i].hold, dw);
      check($sformatf("%s rx_data", vecs[i].name), 32'(rx_data), 32'(vecs[i].exp_rx));
      check($sformatf("%s done latency", vecs[i].name), 32'(dw), 32'(DONE_N + vecs[i].off_len));
      if (i == 4) check("back-to-back done pulses", 32'(done_pulses - base), 32'(2));
    end

    // Reset mid-transfer: aborts with no done pulse and clears rx_data.
    loopback = 1'b1;
    tx_data  = 8'h96;
    start    = 1'b1;
    ena      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre-abort {cs_n,busy}", 32'({cs_n, busy}), 32'(2'b01));
    rstb = 1'b0;
    tick();
    check("abort {sclk,cs_n,mosi,busy,done,rx}",
          32'({sclk, cs_n, mosi, busy, done, rx_data}), 32'({5'b01000, 8'h00}));
    rstb = 1'b1;
    base = done_pulses;
    for (int i = 0; i < 40; i++) tick();
    check("abort no done pulse", 32'(done_pulses - base), 32'(0));
    check("abort stays idle {cs_n,busy}", 32'({cs_n, busy}), 32'(2'b10));
    prev_rx = '0;
    do_transfer("after_abort", 8'h5A, 1, 8'h81, -1, 0, 1'b0, 1'b0, dw);
    check("after_abort rx_data", 32'(rx_data), 32'(8'h81));

    // Randomized transfers with random ena, miso and start noise while busy.
    for (int i = 0; i < 30; i++) begin
      tx   = W'($urandom);
      pw   = W'($urandom);
      mode = 1 + ($urandom % 2);
      do_transfer($sformatf("rand%0d", i), tx, mode, pw, -1, 0, 1'b1, 1'b0, dw);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
